// File: rtl/flash_seq_pkg.sv
// Shared types, JEDEC command constants and the per-op command step table
// for the PRG flash command sequencer.
package flash_seq_pkg;

    typedef enum logic [1:0] {
        OpProgram     = 2'b00,
        OpSectorErase = 2'b01,
        OpChipErase   = 2'b10,
        OpReset       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StWrLo,
        StWrHi,
        StRdLo,
        StRdHi,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        SelAaa,
        Sel555,
        SelReq
    } addr_sel_e;

    localparam logic [11:0] UnlockAddrAaa = 12'hAAA;
    localparam logic [11:0] UnlockAddr555 = 12'h555;

    localparam logic [7:0] CmdAa = 8'hAA;
    localparam logic [7:0] Cmd55 = 8'h55;
    localparam logic [7:0] CmdA0 = 8'hA0;
    localparam logic [7:0] Cmd80 = 8'h80;
    localparam logic [7:0] Cmd30 = 8'h30;
    localparam logic [7:0] Cmd10 = 8'h10;
    localparam logic [7:0] CmdF0 = 8'hF0;

    // use_wdata selects the captured program byte instead of the data field.
    typedef struct packed {
        addr_sel_e   addr_sel;
        logic        use_wdata;
        logic [7:0]  data;
    } step_t;

    function automatic step_t step_lookup(op_e op, logic [2:0] idx);
        step_t s;
        s = '{addr_sel: SelReq, use_wdata: 1'b0, data: CmdF0};
        case (op)
            OpProgram: begin
                case (idx)
                    3'd0:    s = '{addr_sel: SelAaa, use_wdata: 1'b0, data: CmdAa};
                    3'd1:    s = '{addr_sel: Sel555, use_wdata: 1'b0, data: Cmd55};
                    3'd2:    s = '{addr_sel: SelAaa, use_wdata: 1'b0, data: CmdA0};
                    default: s = '{addr_sel: SelReq, use_wdata: 1'b1, data: 8'h00};
                endcase
            end
            OpSectorErase, OpChipErase: begin
                case (idx)
                    3'd0:    s = '{addr_sel: SelAaa, use_wdata: 1'b0, data: CmdAa};
                    3'd1:    s = '{addr_sel: Sel555, use_wdata: 1'b0, data: Cmd55};
                    3'd2:    s = '{addr_sel: SelAaa, use_wdata: 1'b0, data: Cmd80};
                    3'd3:    s = '{addr_sel: SelAaa, use_wdata: 1'b0, data: CmdAa};
                    3'd4:    s = '{addr_sel: Sel555, use_wdata: 1'b0, data: Cmd55};
                    default: begin
                        if (op == OpChipErase) begin
                            s = '{addr_sel: SelAaa, use_wdata: 1'b0, data: Cmd10};
                        end else begin
                            s = '{addr_sel: SelReq, use_wdata: 1'b0, data: Cmd30};
                        end
                    end
                endcase
            end
            default: s = '{addr_sel: SelReq, use_wdata: 1'b0, data: CmdF0};
        endcase
        return s;
    endfunction

    function automatic logic [2:0] last_step(op_e op);
        case (op)
            OpProgram:     return 3'd3;
            OpSectorErase: return 3'd5;
            OpChipErase:   return 3'd5;
            default:       return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// Request/status handshake plus flash pin bundle for flash_cmd_sequencer.
// master = requester/flash side, slave = the sequencer.
interface flash_cmd_sequencer_if #(
    parameter int unsigned ADDR_W = 27
);
    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] flash_addr;
    logic [7:0]        flash_dout;
    logic [7:0]        flash_din;
    logic              flash_drive;
    logic              flash_we_n;
    logic              flash_oe_n;

    modport master (
        output req, op, req_addr, req_data, flash_din,
        input  busy, done, error, flash_addr, flash_dout, flash_drive, flash_we_n, flash_oe_n
    );

    modport slave (
        input  req, op, req_addr, req_data, flash_din,
        output busy, done, error, flash_addr, flash_dout, flash_drive, flash_we_n, flash_oe_n
    );
endinterface

// File: rtl/flash_toggle_poll.sv
// DQ6 toggle / DQ5 fault tracker for embedded-algorithm completion polling.
// Optional poll timeout counter compiled in with FLASH_SEQ_TIMEOUT_EN.
module flash_toggle_poll #(
    parameter int unsigned          TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic sample_i,
    input  logic dq6_i,
    input  logic dq5_i,
    output logic poll_ok_o,
    output logic poll_fail_o
);

    if (TIMEOUT_CYCLES == '0) begin : g_bad_cfg
        $error("flash_toggle_poll: TIMEOUT_CYCLES must be nonzero");
    end

    logic first_q, first_d;
    logic dq6_q, dq6_d;
    logic seen_q, seen_d;
    logic timeout;

`ifdef FLASH_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + TIMEOUT_W'(1);
    // The sample that brings the count to the limit is itself the failing one.
    assign timeout = sample_i && (cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (sample_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        first_d     = first_q;
        dq6_d       = dq6_q;
        seen_d      = seen_q;
        poll_ok_o   = 1'b0;
        poll_fail_o = 1'b0;
        if (start_i) begin
            first_d = 1'b1;
            seen_d  = 1'b0;
        end else if (sample_i) begin
            if (timeout) begin
                poll_fail_o = 1'b1;
            end else if (first_q) begin
                first_d = 1'b0;
                dq6_d   = dq6_i;
            end else if (dq6_i == dq6_q) begin
                poll_ok_o = 1'b1;
            end else if (seen_q) begin
                poll_fail_o = 1'b1;
            end else begin
                // DQ5 only counts as a fault if the next read still toggles.
                seen_d = dq5_i;
                dq6_d  = dq6_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_q <= 1'b1;
            dq6_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            first_q <= first_d;
            dq6_q   <= dq6_d;
            seen_q  <= seen_d;
        end
    end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command sequencer for the PRG flash: program, sector/chip erase, reset.
// Define FLASH_SEQ_TIMEOUT_EN to bound completion polling with a cycle limit.
module flash_cmd_sequencer
    import flash_seq_pkg::*;
#(
    parameter int unsigned          ADDR_W         = 27,
    parameter int unsigned          TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input logic                  m2,
    input logic                  rst_n,
    flash_cmd_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [2:0]        idx_q, idx_d;
    logic              fail_q, fail_d;

    logic              poll_start, poll_sample, poll_ok, poll_fail;
    step_t             step;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_byte;
    logic              unused_din;

    assign unused_din = ^{bus.flash_din[7], bus.flash_din[4:0]};

    assign step    = step_lookup(op_q, idx_q);
    assign wr_byte = step.use_wdata ? wdata_q : step.data;

    always_comb begin
        unique case (step.addr_sel)
            SelAaa:  wr_addr = ADDR_W'(UnlockAddrAaa);
            Sel555:  wr_addr = ADDR_W'(UnlockAddr555);
            default: wr_addr = addr_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        fail_d      = fail_q;
        poll_start  = 1'b0;
        poll_sample = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    op_d    = op_e'(bus.op);
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_data;
                    idx_d   = 3'd0;
                    state_d = StWrLo;
                end
            end
            StWrLo: state_d = StWrHi;
            StWrHi: begin
                if (idx_q != last_step(op_q)) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StWrLo;
                end else if (op_q == OpReset) begin
                    fail_d  = 1'b0;
                    state_d = StFinish;
                end else begin
                    poll_start = 1'b1;
                    state_d    = StRdLo;
                end
            end
            StRdLo: state_d = StRdHi;
            StRdHi: begin
                poll_sample = 1'b1;
                if (poll_fail) begin
                    fail_d  = 1'b1;
                    state_d = StFinish;
                end else if (poll_ok) begin
                    fail_d  = 1'b0;
                    state_d = StFinish;
                end else begin
                    state_d = StRdLo;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Pins are decoded from registered state so reset releases them at once.
    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.error       = 1'b0;
        bus.flash_addr  = '0;
        bus.flash_dout  = '0;
        bus.flash_drive = 1'b0;
        bus.flash_we_n  = 1'b1;
        bus.flash_oe_n  = 1'b1;
        unique case (state_q)
            StWrLo, StWrHi: begin
                bus.busy        = 1'b1;
                bus.flash_addr  = wr_addr;
                bus.flash_dout  = wr_byte;
                bus.flash_drive = 1'b1;
                bus.flash_we_n  = (state_q != StWrLo);
            end
            StRdLo, StRdHi: begin
                bus.busy       = 1'b1;
                bus.flash_addr = addr_q;
                bus.flash_oe_n = 1'b0;
            end
            StFinish: begin
                bus.done  = ~fail_q;
                bus.error = fail_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpProgram;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
        end
    end

    flash_toggle_poll #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_poll (
        .clk_i       (m2),
        .rst_ni      (rst_n),
        .start_i     (poll_start),
        .sample_i    (poll_sample),
        .dq6_i       (bus.flash_din[6]),
        .dq5_i       (bus.flash_din[5]),
        .poll_ok_o   (poll_ok),
        .poll_fail_o (poll_fail)
    );

endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

Sequences JEDEC command cycles to the cartridge PRG flash: program byte, sector erase, chip erase and reset-to-read-array. Accepts one request at a time from the menu/loader logic. Emits the unlock/command write cycles, then polls DQ6 toggle / DQ5 status until the flash finishes. It sits between the config register file and the flash pins (flash address A26–A0, flash_we, flash_oe) and owns those pins while busy.

## Interface
- ADDR_W, 27, flash byte-address width (A26..A0)
- TIMEOUT_W, 24, width of poll timeout counter
- TIMEOUT_CYCLES, 24'hFFFFFF, poll-cycle limit before error (used only with timeout compiled in)
- m2  in  1  clock (CPU M2); all state changes on posedge m2
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled in IDLE
- op  in  2  00 program, 01 sector erase, 10 chip erase, 11 reset (F0)
- req_addr  in  ADDR_W  target byte / sector address
- req_data  in  8  program data (ignored for other ops)
- busy  out  1  high from accept until done/error pulse
- done  out  1  one-cycle success pulse
- error  out  1  one-cycle failure pulse (DQ5 fault or timeout)
- flash_addr  out  ADDR_W  flash address
- flash_dout  out  8  data to flash
- flash_din  in  8  data from flash
- flash_drive  out  1  data-bus output enable
- flash_we_n  out  1  flash write strobe, active low
- flash_oe_n  out  1  flash output enable, active low

## Operation
- Reset values: busy 0, done 0, error 0, flash_we_n 1, flash_oe_n 1, flash_drive 0, flash_addr 0, flash_dout 0. The FSM goes to IDLE.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, FINISH.
- IDLE: if req=1, capture op/req_addr/req_data, set busy=1, step index 0, then go to WR_LO. If req=0, stay. A req while busy is ignored, not queued.
- Command tables (x8 mode):
  - program: AAA/AA, 555/55, AAA/A0, addr/data
  - sector erase: AAA/AA, 555/55, AAA/80, AAA/AA, 555/55, addr/30
  - chip erase: same as sector erase, with final step AAA/10
  - reset: addr/F0
- WR_LO: drive addr/data for the current step; flash_drive=1, flash_we_n=0. Go to WR_HI.
- WR_HI: flash_we_n=1, addr/data held, flash_drive=1. If more steps remain, index+1 and go to WR_LO. If the last step is done, go to FINISH for reset, otherwise go to RD_LO with first_read=1.
- RD_LO: flash_drive=0, flash_oe_n=0, flash_addr=req_addr. Go to RD_HI.
- RD_HI: flash_oe_n held 0; sample flash_din at the end of the cycle.
  - first_read: store DQ6, go to RD_LO.
  - DQ6 equals stored value: success.
  - DQ6 differs and DQ5=1 with dq5_seen=0: set dq5_seen, store DQ6, read again.
  - DQ6 differs and dq5_seen=1: failure.
  - Otherwise: store DQ6, read again.
- FINISH: pulse done or error for one cycle, clear busy, flash_oe_n=1, go to IDLE.
- Step index is 3 bits; unused tables never exceed 6 steps.

## Timing
- Request to first flash_we_n low: 1 cycle.
- Each write costs 2 cycles and each poll read costs 2 cycles.
- Program: 8 write cycles, then at least 4 poll cycles (2 reads) for the earliest done → done asserted no earlier than 13 cycles after accept.
- Reset op: done 3 cycles after accept.
- busy falls in the same cycle done/error is high. A new req is accepted on the following IDLE cycle.
- Reset asserted mid-operation immediately releases pins to reset values. The flash itself may still be busy; software must wait and issue op=11.

## Configuration
- FLASH_SEQ_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter clears on entry to RD_LO from WR_HI and increments each RD_HI.
  - Reaching TIMEOUT_CYCLES forces failure regardless of DQ6/DQ5.
- Undefined: no counter. Polling ends only on toggle stop or DQ5 fault.

## Structure
- Package flash_seq_pkg holds:
  - op encodings
  - FSM state enum
  - command constants (AAA, 555, AA, 55, A0, 80, 30, 10, F0)
  - step-table lookup function returning {addr_sel, data} per op and index
- One sub-module, flash_toggle_poll, holds the DQ6 history, dq5_seen and the optional timeout counter. Its outputs are poll_ok and poll_fail.

## Test plan
- Program, addr 0x012345, data 0x5A; flash model stops toggling after 3 reads → exact 4 write cycles (AAA/AA, 555/55, AAA/A0, 012345/5A); done pulse, error 0.
- Sector erase, addr 0x040000; model sets DQ5 while toggling continues → 6 writes ending 040000/30; error pulse after the read that follows DQ5.
- Chip erase with FLASH_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16; model toggles forever → error pulse after 16 RD_HI cycles, busy 0.
- op=11 reset → single write addr/F0, no flash_oe_n low, done pulse 3 cycles after accept.
- req held high during a program → second request ignored until done; rst_n low mid-WR_LO → flash_we_n=1, flash_drive=0 immediately, busy 0.
